// File: rtl/pd_sched.sv
// Time-multiplexes one shared PD unit across pitch, roll and yaw for each inertial sample,
// then publishes all six P/D results together with a one-cycle terms_rdy pulse.
module pd_sched #(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] d_ptch,
    input  logic signed [15:0] d_roll,
    input  logic signed [15:0] d_yaw,
    input  logic               clr_ovr,
    output logic signed [15:0] pd_actual,
    output logic signed [15:0] pd_desired,
    output logic        [1:0]  pd_axis,
    output logic               pd_vld,
    input  logic signed [9:0]  pd_pterm,
    input  logic signed [11:0] pd_dterm,
    output logic signed [9:0]  ptch_pterm,
    output logic signed [9:0]  roll_pterm,
    output logic signed [9:0]  yaw_pterm,
    output logic signed [11:0] ptch_dterm,
    output logic signed [11:0] roll_dterm,
    output logic signed [11:0] yaw_dterm,
    output logic               terms_rdy,
    output logic               ovr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    state_t             state_r;
    logic        [1:0]  axis_r;
    logic        [2:0]  settle_r;
    logic signed [15:0] snap_ptch_r, snap_roll_r, snap_yaw_r;
    logic signed [15:0] snap_d_ptch_r, snap_d_roll_r, snap_d_yaw_r;
    logic signed [9:0]  hold_ptch_p_r, hold_roll_p_r;
    logic signed [11:0] hold_ptch_d_r, hold_roll_d_r;
    logic               pd_vld_r;

    // Sequencer: snapshot, per-axis settle/strobe, result holding and the sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            axis_r        <= 2'd0;
            settle_r      <= 3'd0;
            snap_ptch_r   <= 16'sd0;
            snap_roll_r   <= 16'sd0;
            snap_yaw_r    <= 16'sd0;
            snap_d_ptch_r <= 16'sd0;
            snap_d_roll_r <= 16'sd0;
            snap_d_yaw_r  <= 16'sd0;
            hold_ptch_p_r <= 10'sd0;
            hold_roll_p_r <= 10'sd0;
            hold_ptch_d_r <= 12'sd0;
            hold_roll_d_r <= 12'sd0;
            ptch_pterm    <= 10'sd0;
            roll_pterm    <= 10'sd0;
            yaw_pterm     <= 10'sd0;
            ptch_dterm    <= 12'sd0;
            roll_dterm    <= 12'sd0;
            yaw_dterm     <= 12'sd0;
            terms_rdy     <= 1'b0;
            ovr           <= 1'b0;
            pd_vld_r      <= 1'b0;
        end else begin
            pd_vld_r  <= 1'b0;
            terms_rdy <= 1'b0;
            // A drop outranks a clear arriving in the same cycle.
            if (vld && (state_r != IDLE)) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (vld) begin
                        snap_ptch_r   <= ptch;
                        snap_roll_r   <= roll;
                        snap_yaw_r    <= yaw;
                        snap_d_ptch_r <= d_ptch;
                        snap_d_roll_r <= d_roll;
                        snap_d_yaw_r  <= d_yaw;
                        axis_r        <= 2'd0;
                        settle_r      <= 3'd0;
                        state_r       <= SETUP;
                    end
                end
                SETUP: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_r <= 3'd0;
                        pd_vld_r <= 1'b1;
                        state_r  <= STROBE;
                    end else begin
                        settle_r <= settle_r + 3'd1;
                    end
                end
                STROBE: begin
                    case (axis_r)
                        2'd0: begin
                            hold_ptch_p_r <= pd_pterm;
                            hold_ptch_d_r <= pd_dterm;
                            axis_r        <= 2'd1;
                            state_r       <= SETUP;
                        end
                        2'd1: begin
                            hold_roll_p_r <= pd_pterm;
                            hold_roll_d_r <= pd_dterm;
                            axis_r        <= 2'd2;
                            state_r       <= SETUP;
                        end
                        default: begin
                            ptch_pterm <= hold_ptch_p_r;
                            ptch_dterm <= hold_ptch_d_r;
                            roll_pterm <= hold_roll_p_r;
                            roll_dterm <= hold_roll_d_r;
                            yaw_pterm  <= pd_pterm;
                            yaw_dterm  <= pd_dterm;
                            terms_rdy  <= 1'b1;
                            axis_r     <= 2'd0;
                            state_r    <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pd_vld = pd_vld_r;

    // Operand mux: present the current axis snapshot only while an axis is being served.
    always_comb begin
        pd_actual  = 16'sd0;
        pd_desired = 16'sd0;
        pd_axis    = 2'd0;
        if ((state_r == SETUP) || (state_r == STROBE)) begin
            pd_axis = axis_r;
            case (axis_r)
                2'd0: begin
                    pd_actual  = snap_ptch_r;
                    pd_desired = snap_d_ptch_r;
                end
                2'd1: begin
                    pd_actual  = snap_roll_r;
                    pd_desired = snap_d_roll_r;
                end
                default: begin
                    pd_actual  = snap_yaw_r;
                    pd_desired = snap_d_yaw_r;
                end
            endcase
        end else begin
            pd_actual  = 16'sd0;
            pd_desired = 16'sd0;
            pd_axis    = 2'd0;
        end
    end

endmodule

// File: tb/tb_pd_sched.sv
// Directed bench for pd_sched: a cycle table for the nominal/overrun run, then hand-written
// sequences for back-to-back samples, drop-versus-clear, mid-sequence reset and SETTLE=3.
module tb_pd_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld, vld3, clr_ovr;
    logic [15:0] ptch, roll, yaw, d_ptch, d_roll, d_yaw;

    logic [15:0] pd_actual, pd_desired, pd_actual3, pd_desired3;
    logic [1:0]  pd_axis, pd_axis3;
    logic        pd_vld, pd_vld3;
    logic [9:0]  pd_pterm, pd_pterm3;
    logic [11:0] pd_dterm, pd_dterm3;
    logic [9:0]  ptch_pterm, roll_pterm, yaw_pterm, ptch_pterm3, roll_pterm3, yaw_pterm3;
    logic [11:0] ptch_dterm, roll_dterm, yaw_dterm, ptch_dterm3, roll_dterm3, yaw_dterm3;
    logic        terms_rdy, ovr, terms_rdy3, ovr3;

    logic [9:0]  pt_tab [3];
    logic [11:0] dt_tab [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in PD unit: fixed per-axis results selected by the axis being served.
    always_comb begin
        pd_pterm  = 10'd0;
        pd_dterm  = 12'd0;
        pd_pterm3 = 10'd0;
        pd_dterm3 = 12'd0;
        if (pd_axis != 2'd3) begin
            pd_pterm = pt_tab[pd_axis];
            pd_dterm = dt_tab[pd_axis];
        end
        if (pd_axis3 != 2'd3) begin
            pd_pterm3 = pt_tab[pd_axis3];
            pd_dterm3 = dt_tab[pd_axis3];
        end
    end

    pd_sched #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .vld(vld),
        .ptch(ptch), .roll(roll), .yaw(yaw),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .clr_ovr(clr_ovr),
        .pd_actual(pd_actual), .pd_desired(pd_desired), .pd_axis(pd_axis), .pd_vld(pd_vld),
        .pd_pterm(pd_pterm), .pd_dterm(pd_dterm),
        .ptch_pterm(ptch_pterm), .roll_pterm(roll_pterm), .yaw_pterm(yaw_pterm),
        .ptch_dterm(ptch_dterm), .roll_dterm(roll_dterm), .yaw_dterm(yaw_dterm),
        .terms_rdy(terms_rdy), .ovr(ovr)
    );

    pd_sched #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .vld(vld3),
        .ptch(ptch), .roll(roll), .yaw(yaw),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .clr_ovr(clr_ovr),
        .pd_actual(pd_actual3), .pd_desired(pd_desired3), .pd_axis(pd_axis3), .pd_vld(pd_vld3),
        .pd_pterm(pd_pterm3), .pd_dterm(pd_dterm3),
        .ptch_pterm(ptch_pterm3), .roll_pterm(roll_pterm3), .yaw_pterm(yaw_pterm3),
        .ptch_dterm(ptch_dterm3), .roll_dterm(roll_dterm3), .yaw_dterm(yaw_dterm3),
        .terms_rdy(terms_rdy3), .ovr(ovr3)
    );

    typedef struct {
        logic        v;
        logic        c;
        logic [15:0] p, r, y, dp, dr, dy;
        logic        e_vld;
        logic [1:0]  e_axis;
        logic [15:0] e_act, e_des;
        logic        e_rdy, e_ovr;
    } vec_t;

    vec_t tv [12];

    function automatic vec_t mk(input logic v, input logic c, input logic garbage,
                                input logic ev, input logic [1:0] ea, input logic [15:0] eact,
                                input logic er, input logic eo);
        vec_t t;
        t.v  = v;
        t.c  = c;
        t.p  = garbage ? 16'h1234 : 16'h0100;
        t.r  = garbage ? 16'h5678 : 16'hFF00;
        t.y  = garbage ? 16'h9ABC : 16'h0020;
        t.dp = garbage ? 16'h1111 : 16'h0000;
        t.dr = garbage ? 16'h2222 : 16'h0000;
        t.dy = garbage ? 16'h3333 : 16'h0000;
        t.e_vld  = ev;
        t.e_axis = ea;
        t.e_act  = eact;
        t.e_des  = 16'h0000;
        t.e_rdy  = er;
        t.e_ovr  = eo;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_res(input string nm, input logic [9:0] p0, input logic [9:0] p1,
                           input logic [9:0] p2, input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2);
        chk({nm, ".ptch_pterm"}, 32'(ptch_pterm), 32'(p0));
        chk({nm, ".roll_pterm"}, 32'(roll_pterm), 32'(p1));
        chk({nm, ".yaw_pterm"},  32'(yaw_pterm),  32'(p2));
        chk({nm, ".ptch_dterm"}, 32'(ptch_dterm), 32'(d0));
        chk({nm, ".roll_dterm"}, 32'(roll_dterm), 32'(d1));
        chk({nm, ".yaw_dterm"},  32'(yaw_dterm),  32'(d2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        vld = 1'b0; vld3 = 1'b0; clr_ovr = 1'b0;
        ptch = 16'h0; roll = 16'h0; yaw = 16'h0;
        d_ptch = 16'h0; d_roll = 16'h0; d_yaw = 16'h0;
        pt_tab = '{10'h011, 10'h022, 10'h033};
        dt_tab = '{12'h011, 12'h022, 12'h033};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pd_vld", 32'(pd_vld), 32'd0);
        chk("rst.terms_rdy", 32'(terms_rdy), 32'd0);
        chk("rst.ovr", 32'(ovr), 32'd0);
        chk("rst.pd_actual", 32'(pd_actual), 32'd0);
        chk_res("rst", 10'h0, 10'h0, 10'h0, 12'h0, 12'h0, 12'h0);
        rst_n = 1'b1;

        // Nominal sample with a dropped vld at cycle 3 and clr_ovr at cycle 10.
        tv[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0);
        tv[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0100, 1'b0, 1'b0);
        tv[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0100, 1'b0, 1'b0);
        tv[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 16'hFF00, 1'b0, 1'b0);
        tv[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'hFF00, 1'b0, 1'b1);
        tv[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h0020, 1'b0, 1'b1);
        tv[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'h0020, 1'b0, 1'b1);
        tv[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1);
        tv[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
        tv[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
        tv[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
        tv[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            tick();
            vld = tv[i].v; clr_ovr = tv[i].c;
            ptch = tv[i].p; roll = tv[i].r; yaw = tv[i].y;
            d_ptch = tv[i].dp; d_roll = tv[i].dr; d_yaw = tv[i].dy;
            #2;
            chk($sformatf("tab%0d.pd_vld", i), 32'(pd_vld), 32'(tv[i].e_vld));
            chk($sformatf("tab%0d.pd_axis", i), 32'(pd_axis), 32'(tv[i].e_axis));
            chk($sformatf("tab%0d.pd_actual", i), 32'(pd_actual), 32'(tv[i].e_act));
            chk($sformatf("tab%0d.pd_desired", i), 32'(pd_desired), 32'(tv[i].e_des));
            chk($sformatf("tab%0d.terms_rdy", i), 32'(terms_rdy), 32'(tv[i].e_rdy));
            chk($sformatf("tab%0d.ovr", i), 32'(ovr), 32'(tv[i].e_ovr));
            if (i >= 7)
                chk_res($sformatf("tab%0d", i), 10'h011, 10'h022, 10'h033, 12'h011, 12'h022, 12'h033);
            else
                chk_res($sformatf("tab%0d", i), 10'h0, 10'h0, 10'h0, 12'h0, 12'h0, 12'h0);
        end
        vld = 1'b0; clr_ovr = 1'b0;

        // Back-to-back samples at cycles 0 and 8 with different PD results each time.
        pt_tab = '{10'h3F0, 10'h155, 10'h0AA};
        dt_tab = '{12'h800, 12'h7FF, 12'h123};
        for (int c = 0; c < 17; c++) begin
            tick();
            vld = (c == 0 || c == 8);
            if (c == 8) begin
                pt_tab = '{10'h200, 10'h1FF, 10'h001};
                dt_tab = '{12'hFFF, 12'h001, 12'h456};
            end
            #2;
            chk($sformatf("b2b%0d.terms_rdy", c), 32'(terms_rdy), 32'(c == 7 || c == 15));
            chk($sformatf("b2b%0d.ovr", c), 32'(ovr), 32'd0);
            if (c >= 7 && c < 15)
                chk_res($sformatf("b2b%0d", c), 10'h3F0, 10'h155, 10'h0AA, 12'h800, 12'h7FF, 12'h123);
            else if (c >= 15)
                chk_res($sformatf("b2b%0d", c), 10'h200, 10'h1FF, 10'h001, 12'hFFF, 12'h001, 12'h456);
        end
        vld = 1'b0;

        // Drop and clr_ovr in the same cycle: the flag must still be set.
        for (int c = 0; c < 9; c++) begin
            tick();
            vld = (c == 0 || c == 2);
            clr_ovr = (c == 2);
            #2;
            if (c == 3) chk("setwins.ovr_c3", 32'(ovr), 32'd1);
            if (c == 8) chk("setwins.ovr_c8", 32'(ovr), 32'd1);
        end
        vld = 1'b0; clr_ovr = 1'b0;

        // Reset at cycle 4 of a sequence: everything clears at once, no terms_rdy follows.
        for (int c = 0; c < 5; c++) begin
            tick();
            vld = (c == 0);
            #2;
        end
        chk("rstmid.pd_vld_before", 32'(pd_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.pd_vld", 32'(pd_vld), 32'd0);
        chk("rstmid.pd_axis", 32'(pd_axis), 32'd0);
        chk("rstmid.pd_actual", 32'(pd_actual), 32'd0);
        chk("rstmid.terms_rdy", 32'(terms_rdy), 32'd0);
        chk("rstmid.ovr", 32'(ovr), 32'd0);
        chk_res("rstmid", 10'h0, 10'h0, 10'h0, 12'h0, 12'h0, 12'h0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            if (terms_rdy) seen = 1'b1;
        end
        chk("rstmid.no_terms_rdy", 32'(seen), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            vld = (c == 0);
            #2;
        end
        chk("rstmid.first_pd_vld", 32'(pd_vld), 32'd1);
        chk("rstmid.first_axis", 32'(pd_axis), 32'd0);
        vld = 1'b0;
        repeat (8) tick();

        // SETTLE=3 instance: strobes at 4, 8, 12 and terms_rdy at 13.
        pt_tab = '{10'h011, 10'h022, 10'h033};
        dt_tab = '{12'h0A1, 12'h0B2, 12'h0C3};
        for (int c = 0; c < 16; c++) begin
            tick();
            vld3 = (c == 0);
            #2;
            chk($sformatf("s3_%0d.pd_vld", c), 32'(pd_vld3), 32'(c == 4 || c == 8 || c == 12));
            chk($sformatf("s3_%0d.terms_rdy", c), 32'(terms_rdy3), 32'(c == 13));
            if (c == 4)  chk("s3.axis4", 32'(pd_axis3), 32'd0);
            if (c == 8)  chk("s3.axis8", 32'(pd_axis3), 32'd1);
            if (c == 12) chk("s3.axis12", 32'(pd_axis3), 32'd2);
        end
        vld3 = 1'b0;
        chk("s3.ptch_dterm", 32'(ptch_dterm3), 32'h0A1);
        chk("s3.roll_dterm", 32'(roll_dterm3), 32'h0B2);
        chk("s3.yaw_dterm", 32'(yaw_dterm3), 32'h0C3);
        chk("s3.yaw_pterm", 32'(yaw_pterm3), 32'h033);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
